// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave,
// counted in cycles of the fast system clock.
module clk_period_meter #(
    parameter int CNT_WIDTH   = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ena,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   ena_s_q;

    state_e state_q, state_d;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Edge strobes are registered so the FSM acts on edge SYNC_STAGES+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            s_d_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ena_s_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d_q   <= s;
            rise_q  <= s & ~s_d_q;
            fall_q  <= ~s & s_d_q;
            ena_s_q <= ena;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ena_s_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = WAIT_EDGE;
                WAIT_EDGE: if (rise_q) state_d = MEASURE;
                MEASURE: begin
                    if (!rise_q && cnt_q == CNT_MAX) begin
                        state_d = WAIT_EDGE;
                    end
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_cap_d = hi_cap_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        if (!ena_s_q || state_q == IDLE) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_EDGE: begin
                    if (rise_q) cnt_d = CNT_ONE;
                end
                MEASURE: begin
                    // A rise landing on a saturated count still reports.
                    if (rise_q) begin
                        period_d = cnt_q;
                        high_d   = hi_cap_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (fall_q) hi_cap_d = cnt_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_cap_q <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_cap_q <= hi_cap_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign overflow  = ovf_q;

endmodule
